// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ccff_state_e;

  // Number of bitstream words needed to cover a chain of chainLen bits.
  function automatic int ccff_words(input int chainLen, input int wordW);
    return (chainLen + wordW - 1) / wordW;
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream (valid/ready) feeding the configuration-chain loader.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 32
) ();

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/ccff_word_serializer.sv
// One-entry prefetch buffer plus MSB-first shift register; o_head is the bit on ccff_head.
module ccff_word_serializer #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_advance,
  output logic              o_head,
  output logic              o_bufEmpty,
  output logic              o_canAdvance
);

  localparam int LEFT_W = $clog2(WORD_W);

  logic [WORD_W-1:0] r_shift;
  logic [WORD_W-1:0] r_buf;
  logic [LEFT_W-1:0] r_left;
  logic              r_bufFull;
  logic              r_head;
  logic              w_wordEmpty;
  logic              w_takeDirect;

  assign w_wordEmpty  = (r_left == '0);
  // An exhausted word with an empty buffer takes a same-cycle pushed word straight in.
  assign w_takeDirect = i_advance && w_wordEmpty && !r_bufFull;
  assign o_canAdvance = !w_wordEmpty || r_bufFull || i_push;
  assign o_bufEmpty   = !r_bufFull;
  assign o_head       = r_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_buf     <= '0;
      r_left    <= '0;
      r_bufFull <= 1'b0;
      r_head    <= 1'b0;
    end else if (i_clear) begin
      r_left    <= '0;
      r_bufFull <= 1'b0;
    end else begin
      if (i_advance) begin
        if (!w_wordEmpty) begin
          r_head  <= r_shift[WORD_W-1];
          r_shift <= {r_shift[WORD_W-2:0], 1'b0};
          r_left  <= r_left - LEFT_W'(1);
        end else if (r_bufFull) begin
          r_head    <= r_buf[WORD_W-1];
          r_shift   <= {r_buf[WORD_W-2:0], 1'b0};
          r_left    <= LEFT_W'(WORD_W - 1);
          r_bufFull <= 1'b0;
        end else begin
          r_head  <= i_data[WORD_W-1];
          r_shift <= {i_data[WORD_W-2:0], 1'b0};
          r_left  <= LEFT_W'(WORD_W - 1);
        end
      end
      if (i_push && !w_takeDirect) begin
        r_buf     <= i_data;
        r_bufFull <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words onto the configuration chain and counts exactly CHAIN_LEN shifts.
// Define CCFF_LOADER_READBACK_EN to add ccff_tail capture into rb_data/rb_valid.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic prog_clk,
  input  logic prog_reset_n,
  input  logic start,
  ccff_chain_loader_if.slave in_bus,
  output logic ccff_head,
  output logic chain_shift_en,
  output logic busy,
  output logic done
`ifdef CCFF_LOADER_READBACK_EN
  ,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  localparam int NWORDS  = ccff_words(CHAIN_LEN, WORD_W);
  localparam int WCNT_W  = $clog2(NWORDS + 1);

  ccff_state_e       r_state;
  ccff_state_e       w_nextState;
  logic [CNT_W-1:0]  r_bitCnt;
  logic [WCNT_W-1:0] r_wordCnt;
  logic              w_startLoad;
  logic              w_push;
  logic              w_advance;
  logic              w_lastShift;
  logic              w_bufEmpty;
  logic              w_canAdvance;
  logic              w_head;

  assign busy            = (r_state == FILL) || (r_state == SHIFT);
  assign done            = (r_state == DONE);
  assign chain_shift_en  = (r_state == SHIFT);
  assign ccff_head       = w_head;
  assign w_startLoad     = start && ((r_state == IDLE) || (r_state == DONE));
  assign in_bus.in_ready = busy && w_bufEmpty && (r_wordCnt < WCNT_W'(NWORDS));
  assign w_push          = in_bus.in_valid && in_bus.in_ready;
  assign w_lastShift     = (r_state == SHIFT) && (r_bitCnt == CNT_W'(CHAIN_LEN - 1));

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_advance   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) w_nextState = FILL;
      end
      FILL: begin
        if (w_push) begin
          w_advance   = 1'b1;
          w_nextState = SHIFT;
        end
      end
      SHIFT: begin
        // The remaining bits of a partial final word are simply never advanced into.
        if (w_lastShift) begin
          w_nextState = DONE;
        end else if (w_canAdvance) begin
          w_advance = 1'b1;
        end else begin
          w_nextState = FILL;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_bitCnt  <= '0;
      r_wordCnt <= '0;
    end else if (w_startLoad) begin
      r_bitCnt  <= '0;
      r_wordCnt <= '0;
    end else begin
      if (r_state == SHIFT) r_bitCnt <= r_bitCnt + CNT_W'(1);
      if (w_push) r_wordCnt <= r_wordCnt + WCNT_W'(1);
    end
  end

  ccff_word_serializer #(.WORD_W(WORD_W)) u_serializer (
    .clk         (prog_clk),
    .rst_n       (prog_reset_n),
    .i_clear     (w_startLoad),
    .i_push      (w_push),
    .i_data      (in_bus.in_data),
    .i_advance   (w_advance),
    .o_head      (w_head),
    .o_bufEmpty  (w_bufEmpty),
    .o_canAdvance(w_canAdvance)
  );

`ifdef CCFF_LOADER_READBACK_EN
  localparam int RB_W = $clog2(WORD_W);

  logic [RB_W-1:0]   r_rbCnt;
  logic [RB_W-1:0]   w_rbIdx;
  logic [WORD_W-1:0] r_rbAcc;
  logic [WORD_W-1:0] w_rbBit;
  logic [WORD_W-1:0] w_rbNext;
  logic [WORD_W-1:0] r_rbData;
  logic              r_rbValid;

  // Tail bits fill from the MSB down, so a short final word comes out left-justified.
  always_comb begin
    w_rbIdx          = RB_W'(WORD_W - 1) - r_rbCnt;
    w_rbBit          = '0;
    w_rbBit[w_rbIdx] = ccff_tail;
    w_rbNext         = r_rbAcc | w_rbBit;
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_rbCnt   <= '0;
      r_rbAcc   <= '0;
      r_rbData  <= '0;
      r_rbValid <= 1'b0;
    end else begin
      r_rbValid <= 1'b0;
      if (w_startLoad) begin
        r_rbCnt <= '0;
        r_rbAcc <= '0;
      end else if (chain_shift_en) begin
        if ((r_rbCnt == RB_W'(WORD_W - 1)) || w_lastShift) begin
          r_rbData  <= w_rbNext;
          r_rbValid <= 1'b1;
          r_rbAcc   <= '0;
          r_rbCnt   <= '0;
        end else begin
          r_rbAcc <= w_rbNext;
          r_rbCnt <= r_rbCnt + RB_W'(1);
        end
      end
    end
  end

  assign rb_data  = r_rbData;
  assign rb_valid = r_rbValid;
`else
  // Without readback the chain tail is not observed at all.
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench: a 32-bit and a 40-bit chain loader driven side by side from one clock.
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  logic rstn32 = 1'b0, start32 = 1'b0, head32, en32, busy32, done32;
  logic rstn40 = 1'b0, start40 = 1'b0, head40, en40, busy40, done40;

  ccff_chain_loader_if #(.WORD_W(32)) bus32 ();
  ccff_chain_loader_if #(.WORD_W(32)) bus40 ();

  initial begin
    bus32.in_data = '0; bus32.in_valid = 1'b0;
    bus40.in_data = '0; bus40.in_valid = 1'b0;
  end

`ifdef CCFF_LOADER_READBACK_EN
  logic [31:0] chain32 = '0;
  logic        tail32, rbv32, rbv40;
  logic        tail40 = 1'b0;
  logic [31:0] rbd32, rbd40;
  logic [31:0] rbData32[$];
  int          rbCyc32[$];
  always @(posedge clk) if (en32) chain32 <= {chain32[30:0], head32};
  assign tail32 = chain32[31];
  always @(negedge clk) begin
    if (rbv32) begin
      rbData32.push_back(rbd32);
      rbCyc32.push_back(cyc);
    end
  end
`endif

  ccff_chain_loader #(.WORD_W(32), .CHAIN_LEN(32)) u32 (
    .prog_clk(clk), .prog_reset_n(rstn32), .start(start32), .in_bus(bus32),
    .ccff_head(head32), .chain_shift_en(en32), .busy(busy32), .done(done32)
`ifdef CCFF_LOADER_READBACK_EN
    , .ccff_tail(tail32), .rb_data(rbd32), .rb_valid(rbv32)
`endif
  );

  ccff_chain_loader #(.WORD_W(32), .CHAIN_LEN(40)) u40 (
    .prog_clk(clk), .prog_reset_n(rstn40), .start(start40), .in_bus(bus40),
    .ccff_head(head40), .chain_shift_en(en40), .busy(busy40), .done(done40)
`ifdef CCFF_LOADER_READBACK_EN
    , .ccff_tail(tail40), .rb_data(rbd40), .rb_valid(rbv40)
`endif
  );

  // Shift stream, stall gaps, handshakes and done edges recorded per loader.
  logic bits32[$];
  int   gaps32[$];
  int   heldBad32 = 0, hs32 = 0, lastShift32 = 0, doneRise32 = -1, gapRun32 = 0;
  logic seen32 = 1'b0, lastHead32 = 1'b0, prevDone32 = 1'b0;
  always @(negedge clk) begin
    if (en32) begin
      if (seen32 && gapRun32 > 0) gaps32.push_back(gapRun32);
      bits32.push_back(head32);
      lastShift32 = cyc; seen32 = 1'b1; gapRun32 = 0; lastHead32 = head32;
    end else if (busy32 && seen32) begin
      gapRun32++;
      if (head32 !== lastHead32) heldBad32++;
    end else if (!busy32) begin
      seen32 = 1'b0; gapRun32 = 0;
    end
    if (done32 && !prevDone32) doneRise32 = cyc;
    prevDone32 = done32;
    if (bus32.in_valid && bus32.in_ready) hs32++;
  end

  logic bits40[$];
  int   gaps40[$];
  int   heldBad40 = 0, hs40 = 0, lastShift40 = 0, doneRise40 = -1, gapRun40 = 0;
  logic seen40 = 1'b0, lastHead40 = 1'b0, prevDone40 = 1'b0;
  always @(negedge clk) begin
    if (en40) begin
      if (seen40 && gapRun40 > 0) gaps40.push_back(gapRun40);
      bits40.push_back(head40);
      lastShift40 = cyc; seen40 = 1'b1; gapRun40 = 0; lastHead40 = head40;
    end else if (busy40 && seen40) begin
      gapRun40++;
      if (head40 !== lastHead40) heldBad40++;
    end else if (!busy40) begin
      seen40 = 1'b0; gapRun40 = 0;
    end
    if (done40 && !prevDone40) doneRise40 = cyc;
    prevDone40 = done40;
    if (bus40.in_valid && bus40.in_ready) hs40++;
  end

  function automatic logic [31:0] grab32(input int base);
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++) if (base + i < bits32.size()) w[31-i] = bits32[base+i];
    return w;
  endfunction

  function automatic logic [39:0] grab40(input int base);
    logic [39:0] w = '0;
    for (int i = 0; i < 40; i++) if (base + i < bits40.size()) w[39-i] = bits40[base+i];
    return w;
  endfunction

  task automatic load32(input logic [31:0] word, output bit ok);
    @(posedge clk); #1 start32 = 1'b1; bus32.in_data = word; bus32.in_valid = 1'b1;
    @(posedge clk); #1 start32 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done32) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1 bus32.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({bus32.in_ready, head32, en32, busy32, done32} !== 5'b0) begin
      bad++; $display("[TB] FAIL reset_outputs32 got=%b want=00000", {bus32.in_ready, head32, en32, busy32, done32});
    end
    total++;
    if ({bus40.in_ready, head40, en40, busy40, done40} !== 5'b0) begin
      bad++; $display("[TB] FAIL reset_outputs40 got=%b want=00000", {bus40.in_ready, head40, en40, busy40, done40});
    end
`ifdef CCFF_LOADER_READBACK_EN
    total++;
    if ({rbv32, rbd32} !== 33'h0) begin
      bad++; $display("[TB] FAIL reset_readback got=%b/%h want=0/00000000", rbv32, rbd32);
    end
`endif
    @(posedge clk); #1 rstn32 = 1'b1; rstn40 = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single_word();
    int base = bits32.size(); int hsBase = hs32; int gBase = gaps32.size(); bit ok = 1'b0;
    @(posedge clk); #1 start32 = 1'b1; bus32.in_data = 32'hA5A50F0F; bus32.in_valid = 1'b1;
    @(posedge clk); #1 start32 = 1'b0;
    @(negedge clk);
    total++;
    if ({busy32, bus32.in_ready} !== 2'b11) begin
      bad++; $display("[TB] FAIL start_latency busy,ready got=%b want=11", {busy32, bus32.in_ready});
    end
    for (int i = 0; i < 100; i++) begin
      if (done32) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk); #1 bus32.in_valid = 1'b0;
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL single_timeout got=no_done want=done"); end
    total++;
    if (bits32.size() - base != 32) begin
      bad++; $display("[TB] FAIL single_count got=%0d want=32", bits32.size() - base);
    end
    total++;
    if (grab32(base) !== 32'hA5A50F0F) begin
      bad++; $display("[TB] FAIL single_stream got=%h want=a5a50f0f", grab32(base));
    end
    total++;
    if (doneRise32 != lastShift32 + 1) begin
      bad++; $display("[TB] FAIL single_done_latency got=%0d want=%0d", doneRise32, lastShift32 + 1);
    end
    total++;
    if (busy32 !== 1'b0) begin bad++; $display("[TB] FAIL single_busy_at_done got=%b want=0", busy32); end
    total++;
    if (hs32 - hsBase != 1) begin bad++; $display("[TB] FAIL single_handshakes got=%0d want=1", hs32 - hsBase); end
    total++;
    if (gaps32.size() != gBase) begin bad++; $display("[TB] FAIL single_bubbles got=%0d want=0", gaps32.size() - gBase); end
    repeat (3) @(negedge clk);
    total++;
    if (done32 !== 1'b1) begin bad++; $display("[TB] FAIL single_done_held got=%b want=1", done32); end
  endtask

  task automatic test_two_words();
    int base = bits40.size(); int hsBase = hs40; int gBase = gaps40.size(); int n = 0; bit ok = 1'b0;
    logic [39:0] got;
    @(posedge clk); #1 start40 = 1'b1; bus40.in_data = 32'hFFFFFFFF; bus40.in_valid = 1'b1;
    @(posedge clk); #1 start40 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus40.in_valid && bus40.in_ready) n++;
      if (done40) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      if (n == 1) bus40.in_data = 32'h81000000;
      else if (n >= 2) bus40.in_data = 32'hDEADBEEF;
    end
    repeat (3) @(posedge clk);
    #1 bus40.in_valid = 1'b0;
    got = grab40(base);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL two_timeout got=no_done want=done"); end
    total++;
    if (bits40.size() - base != 40) begin bad++; $display("[TB] FAIL two_count got=%0d want=40", bits40.size() - base); end
    total++;
    if (got[39:8] !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL two_first_word got=%h want=ffffffff", got[39:8]); end
    total++;
    if (got[7:0] !== 8'h81) begin bad++; $display("[TB] FAIL two_last_bits got=%b want=10000001", got[7:0]); end
    total++;
    if (gaps40.size() != gBase) begin bad++; $display("[TB] FAIL two_bubbles got=%0d want=0", gaps40.size() - gBase); end
    total++;
    if (hs40 - hsBase != 2) begin bad++; $display("[TB] FAIL two_no_third_word got=%0d want=2", hs40 - hsBase); end
    total++;
    if (doneRise40 != lastShift40 + 1) begin
      bad++; $display("[TB] FAIL two_done_latency got=%0d want=%0d", doneRise40, lastShift40 + 1);
    end
  endtask

  task automatic test_stall_gap();
    int base = bits40.size(); int hsBase = hs40; int gBase = gaps40.size(); int hBase = heldBad40;
    bit ok = 1'b0; bit saw = 1'b0; logic [39:0] got;
    @(posedge clk); #1 start40 = 1'b1; bus40.in_data = 32'hFFFFFFFF; bus40.in_valid = 1'b1;
    @(posedge clk); #1 start40 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus40.in_valid && bus40.in_ready) break;
    end
    @(posedge clk); #1 bus40.in_valid = 1'b0; bus40.in_data = 32'h81000000;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (en40) saw = 1'b1;
      else if (saw) break;
    end
    repeat (4) @(posedge clk);
    #1 bus40.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus40.in_valid && bus40.in_ready) break;
    end
    @(posedge clk); #1 bus40.in_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done40) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    got = grab40(base);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL gap_timeout got=no_done want=done"); end
    total++;
    if (got !== 40'hFFFFFFFF81 || bits40.size() - base != 40) begin
      bad++; $display("[TB] FAIL gap_stream got=%h/%0d want=ffffffff81/40", got, bits40.size() - base);
    end
    total++;
    if (gaps40.size() - gBase != 1 || (gaps40.size() > gBase && gaps40[gBase] != 5)) begin
      bad++; $display("[TB] FAIL gap_length got=%0d gaps want=1 gap of 5", gaps40.size() - gBase);
    end
    total++;
    if (heldBad40 != hBase) begin bad++; $display("[TB] FAIL gap_head_held got=%0d changes want=0", heldBad40 - hBase); end
    total++;
    if (hs40 - hsBase != 2) begin bad++; $display("[TB] FAIL gap_handshakes got=%0d want=2", hs40 - hsBase); end
  endtask

  task automatic test_start_ignored();
    int base = bits32.size(); int hsBase = hs32; int n = 0; bit ok = 1'b0; bit pulsed = 1'b0;
    @(posedge clk); #1 start32 = 1'b1; bus32.in_data = 32'h3C5AA5C3; bus32.in_valid = 1'b1;
    @(posedge clk); #1 start32 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (en32) n++;
      if (done32) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      if (n == 10 && !pulsed) begin start32 = 1'b1; pulsed = 1'b1; end
      else start32 = 1'b0;
    end
    @(posedge clk); #1 start32 = 1'b0; bus32.in_valid = 1'b0;
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL busy_start_timeout got=no_done want=done"); end
    total++;
    if (bits32.size() - base != 32) begin bad++; $display("[TB] FAIL busy_start_count got=%0d want=32", bits32.size() - base); end
    total++;
    if (grab32(base) !== 32'h3C5AA5C3) begin bad++; $display("[TB] FAIL busy_start_stream got=%h want=3c5aa5c3", grab32(base)); end
    total++;
    if (hs32 - hsBase != 1) begin bad++; $display("[TB] FAIL busy_start_handshakes got=%0d want=1", hs32 - hsBase); end
  endtask

  task automatic test_reset_mid_load();
    int n = 0; int base; bit ok;
    @(posedge clk); #1 start32 = 1'b1; bus32.in_data = 32'hF0F0F0F0; bus32.in_valid = 1'b1;
    @(posedge clk); #1 start32 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (en32) n++;
      if (n == 17) break;
    end
    rstn32 = 1'b0;
    #1;
    total++;
    if ({bus32.in_ready, head32, en32, busy32, done32} !== 5'b0) begin
      bad++; $display("[TB] FAIL midreset_outputs got=%b want=00000", {bus32.in_ready, head32, en32, busy32, done32});
    end
    @(posedge clk); #1 bus32.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn32 = 1'b1;
    @(negedge clk);
    total++;
    if ({busy32, done32} !== 2'b00) begin bad++; $display("[TB] FAIL midreset_idle got=%b want=00", {busy32, done32}); end
    base = bits32.size();
    load32(32'h3C3CC3C3, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL reload_timeout got=no_done want=done"); end
    total++;
    if (grab32(base) !== 32'h3C3CC3C3 || bits32.size() - base != 32) begin
      bad++; $display("[TB] FAIL reload_stream got=%h/%0d want=3c3cc3c3/32", grab32(base), bits32.size() - base);
    end
  endtask

`ifdef CCFF_LOADER_READBACK_EN
  task automatic test_readback();
    bit ok1, ok2; int rbBase;
    load32(32'h12345678, ok1);
    @(posedge clk); #1;
    rbBase = rbData32.size();
    load32(32'hCAFEBABE, ok2);
    @(posedge clk); #1;
    total++;
    if (!(ok1 && ok2)) begin bad++; $display("[TB] FAIL rb_timeout got=%b%b want=11", ok1, ok2); end
    total++;
    if (rbData32.size() - rbBase != 1) begin bad++; $display("[TB] FAIL rb_pulses got=%0d want=1", rbData32.size() - rbBase); end
    else begin
      total++;
      if (rbData32[rbBase] !== 32'h12345678) begin bad++; $display("[TB] FAIL rb_data got=%h want=12345678", rbData32[rbBase]); end
      total++;
      if (rbCyc32[rbBase] != doneRise32) begin bad++; $display("[TB] FAIL rb_timing got=%0d want=%0d", rbCyc32[rbBase], doneRise32); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_two_words();
    test_stall_gap();
    test_start_ignored();
    test_reset_mid_load();
`ifdef CCFF_LOADER_READBACK_EN
    test_readback();
`endif
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain loader that sits directly upstream of the routing fabric's configuration flip-flop chain (switch blocks, connection blocks, grid tiles). It accepts bitstream words over a valid/ready stream and serializes them, MSB first, onto `ccff_head` of the first tile in the chain. It emits a per-cycle shift enable that gates `prog_clk` toward the chain and reports completion once exactly `CHAIN_LEN` bits have been shifted. It can also capture the bits emerging from the chain's `ccff_tail` for readback.

## Interface
- `WORD_W`, 32: bitstream word width; must be ≥ 2.
- `CHAIN_LEN`, 32: total configuration bits in the chain; must be ≥ 1.
- `CNT_W`, `$clog2(CHAIN_LEN+1)`: width of the bit counter (derived).

- `prog_clk`  in  1  configuration clock; free-running.
- `prog_reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse that begins a load.
- `in_data`  in  WORD_W  bitstream word; the MSB is shifted first.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts `in_data` in this cycle.
- `ccff_head`  out  1  serial data into the first chain cell (registered).
- `chain_shift_en`  out  1  chain cells capture `ccff_head` at the rising edge that ends this cycle. This drives the top-level `prog_clk` gate.
- `busy`  out  1  a load is in progress.
- `done`  out  1  the last load completed; held until the next accepted `start`.
- `ccff_tail`  in  1  serial output of the last chain cell (readback only).
- `rb_data`  out  WORD_W  readback word (readback only).
- `rb_valid`  out  1  one-cycle pulse, `rb_data` is valid (readback only).

## Operation
- States: IDLE, FILL, SHIFT, DONE.
  - IDLE/DONE → FILL when `start` is high. This clears the bit counter and `done`, and sets `busy`.
  - FILL: the shift register is empty and the loader waits for a word. FILL → SHIFT on an `in_valid && in_ready` handshake.
  - SHIFT: one bit leaves per cycle.
    - When the current word is exhausted and the prefetch buffer is full, the buffer is loaded with no bubble.
    - When the word is exhausted and the buffer is empty, go to FILL.
    - When the bit counter reaches `CHAIN_LEN`, go to DONE.
- One-entry prefetch buffer. `in_ready` = `busy` && buffer empty && (words accepted < ceil(`CHAIN_LEN`/`WORD_W`)).
- Bit order: bit `WORD_W-1` goes first. In the final word only the top `CHAIN_LEN mod WORD_W` bits are shifted (all bits if the remainder is 0); its low bits are discarded.
- Extra words beyond the required count are never accepted (`in_ready` stays low).
- `start` while `busy` is ignored.
- `chain_shift_en` is high for exactly `CHAIN_LEN` cycles per load, and only in SHIFT.
- During stalls (FILL), `ccff_head` holds its last value and `chain_shift_en` = 0.
- Reset values: `in_ready` 0, `ccff_head` 0, `chain_shift_en` 0, `busy` 0, `done` 0, `rb_valid` 0, `rb_data` 0.
- Reset mid-load:
  - Immediate return to IDLE; the partial word is dropped.
  - Chain contents are undefined. Recovery requires a full reload.

## Timing
- `start` is sampled in cycle 0; `busy` = 1 and `in_ready` may be 1 in cycle 1.
- Handshake in cycle t: first `chain_shift_en` = 1 in cycle t+1, with `ccff_head` = `in_data[WORD_W-1]`.
- With `in_valid` held high, bits are continuous at 1 bit/cycle.
- Last `chain_shift_en` in cycle L. In cycle L+1: `done` = 1, `busy` = 0.
- Bit counter width is `CNT_W`. It never wraps, because the transition to DONE happens at `CHAIN_LEN`.

## Configuration
- `CCFF_LOADER_READBACK_EN` defined:
  - `ccff_tail` is sampled in every `chain_shift_en` cycle (this is the value being displaced) and packed MSB first into `rb_data`.
  - `rb_valid` pulses the cycle after each `WORD_W`-th sampled bit.
  - A final partial word is left-justified with zero fill and pulses in the cycle `done` rises.
- Not defined: `ccff_tail`, `rb_data` and `rb_valid` are absent from the port list, and no readback logic exists.

## Structure
- Package `ccff_loader_pkg`: the state enum type and the `ccff_words(CHAIN_LEN, WORD_W)` ceiling-division function.
- One sub-module, `ccff_word_serializer`: prefetch buffer, shift register and word-exhausted flag. The top level holds the FSM, bit counter and readback packer.

## Test plan
- `CHAIN_LEN`=32, `WORD_W`=32, word 0xA5A50F0F, `in_valid` held high:
  - `ccff_head` sequence 1,0,1,0,0,1,0,1,… over 32 consecutive `chain_shift_en` cycles.
  - `done` one cycle after the last shift.
- `CHAIN_LEN`=40, words 0xFFFFFFFF and 0x81000000:
  - 40 shifts, no bubble between words.
  - The last 8 bits are 1,0,0,0,0,0,0,1.
  - A third word is never accepted.
- Same as the 40-bit case, but `in_valid` is dropped for 5 cycles between words: a 5-cycle `chain_shift_en` gap with `ccff_head` held, and the shifted bit stream is unchanged.
- `start` pulsed at shift 10 of an active load: ignored; the load completes with exactly `CHAIN_LEN` shifts.
- `prog_reset_n` asserted at shift 17: all outputs are at their reset values immediately. A subsequent full load produces the correct 32-bit stream.
- With `CCFF_LOADER_READBACK_EN`, a 32-cell behavioural chain, and load 0x12345678 then load 0xCAFEBABE: the second load pulses `rb_valid` once with `rb_data` = 0x12345678.
